datacache: RTL and testbench

Write-back, write-allocate, direct-mapped data cache between the CPU memory stage and data memory; the write-side counterpart of the read-only instruction cache. Reads hit in one cycle. Writes update the line and mark it dirty. A miss evicts a dirty victim to memory before refilling the line, and a flush command writes every dirty line back. Organisation: 4 lines of 256 bits (8 × 32-bit words); address split is tag [31:7], index [6:5], word [4:2], with [1:0] ignored.

---
 rtl/datacache_pkg.sv | 31 +++
 rtl/datacache_array.sv | 46 ++++
 rtl/datacache.sv | 214 +++++++++++++++++++++
 tb/tb_datacache.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datacache_pkg.sv
// rtl/datacache_pkg.sv - shared widths, state encoding and line word helpers for datacache
package datacache_pkg;
  localparam int WORD_SIZE        = 32;
  localparam int BLOCK_SIZE       = 256;
  localparam int CACHE_GROUP      = 4;
  localparam int CACHE_TAG_LEN    = 25;
  localparam int CACHE_INDEX_LEN  = 2;
  localparam int CACHE_OFFSET_LEN = 5;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    FLUSH_SCAN,
    FLUSH_WB
  } state_t;

  function automatic logic [BLOCK_SIZE-1:0] merge_word(input logic [BLOCK_SIZE-1:0] line,
                                                       input logic [2:0] w,
                                                       input logic [WORD_SIZE-1:0] data);
    logic [BLOCK_SIZE-1:0] r;
    r = line;
    r[int'(w)*WORD_SIZE +: WORD_SIZE] = data;
    return r;
  endfunction

  function automatic logic [WORD_SIZE-1:0] get_word(input logic [BLOCK_SIZE-1:0] line,
                                                    input logic [2:0] w);
    return line[int'(w)*WORD_SIZE +: WORD_SIZE];
  endfunction
endpackage

// File: rtl/datacache_array.sv
// rtl/datacache_array.sv - tag/valid/dirty/data storage, combinational read, per-field write enables
module datacache_array
  import datacache_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CACHE_INDEX_LEN-1:0] idx,
  output logic [CACHE_TAG_LEN-1:0]   rd_tag,
  output logic                       rd_valid,
  output logic                       rd_dirty,
  output logic [BLOCK_SIZE-1:0]      rd_line,
  input  logic                       line_we,
  input  logic [BLOCK_SIZE-1:0]      wr_line,
  input  logic                       tag_we,
  input  logic [CACHE_TAG_LEN-1:0]   wr_tag,
  input  logic                       valid_we,
  input  logic                       wr_valid,
  input  logic                       dirty_we,
  input  logic                       wr_dirty
);
  logic [BLOCK_SIZE-1:0]    data_q [CACHE_GROUP];
  logic [CACHE_TAG_LEN-1:0] tag_q  [CACHE_GROUP];
  logic [CACHE_GROUP-1:0]   valid_q;
  logic [CACHE_GROUP-1:0]   dirty_q;

  assign rd_tag   = tag_q[idx];
  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_line  = data_q[idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (valid_we) valid_q[idx] <= wr_valid;
      if (dirty_we) dirty_q[idx] <= wr_dirty;
    end
  end

  // Payload needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (line_we) data_q[idx] <= wr_line;
    if (tag_we)  tag_q[idx]  <= wr_tag;
  end
endmodule

// File: rtl/datacache.sv
// rtl/datacache.sv - write-back, write-allocate, direct-mapped data cache with flush
module datacache
  import datacache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [WORD_SIZE-1:0]  req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [WORD_SIZE-1:0]  resp_rdata,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wline,
  input  logic                  mem_ack,
  input  logic [BLOCK_SIZE-1:0] mem_rline
);
  state_t state, state_n;
  logic [1:0]  ptr, ptr_n;
  logic        lat_write;
  logic [31:2] lat_addr;
  logic [WORD_SIZE-1:0] lat_wdata;

  logic mem_req_n, mem_we_n, resp_valid_n, flush_done_n;
  logic [31:0] mem_addr_n;
  logic [BLOCK_SIZE-1:0] mem_wline_n;
  logic [WORD_SIZE-1:0] resp_rdata_n;

  logic [CACHE_INDEX_LEN-1:0] idx;
  logic [CACHE_TAG_LEN-1:0] rd_tag, wr_tag;
  logic rd_valid, rd_dirty, hit, accept;
  logic [BLOCK_SIZE-1:0] rd_line, wr_line;
  logic line_we, tag_we, valid_we, wr_valid, dirty_we, wr_dirty;
  logic unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];
  assign req_ready = rst_n && (state == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign hit       = rd_valid && (rd_tag == req_addr[31:7]);

  // One shared port: lookup by incoming address, pending miss, or flush pointer.
  always_comb begin
    case (state)
      IDLE:                 idx = req_addr[6:5];
      FLUSH_SCAN, FLUSH_WB: idx = ptr;
      default:              idx = lat_addr[6:5];
    endcase
  end

  datacache_array u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (idx),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_line  (rd_line),
    .line_we  (line_we),
    .wr_line  (wr_line),
    .tag_we   (tag_we),
    .wr_tag   (wr_tag),
    .valid_we (valid_we),
    .wr_valid (wr_valid),
    .dirty_we (dirty_we),
    .wr_dirty (wr_dirty)
  );

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    mem_req_n    = mem_req;
    mem_we_n     = mem_we;
    mem_addr_n   = mem_addr;
    mem_wline_n  = mem_wline;
    resp_valid_n = 1'b0;
    resp_rdata_n = '0;
    flush_done_n = 1'b0;
    line_we      = 1'b0;
    wr_line      = rd_line;
    tag_we       = 1'b0;
    wr_tag       = lat_addr[31:7];
    valid_we     = 1'b0;
    wr_valid     = 1'b0;
    dirty_we     = 1'b0;
    wr_dirty     = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          state_n = FLUSH_SCAN;
          ptr_n   = 2'd0;
        end else if (accept) begin
          if (hit) begin
            resp_valid_n = 1'b1;
            if (req_write) begin
              line_we  = 1'b1;
              wr_line  = merge_word(rd_line, req_addr[4:2], req_wdata);
              dirty_we = 1'b1;
              wr_dirty = 1'b1;
            end else begin
              resp_rdata_n = get_word(rd_line, req_addr[4:2]);
            end
          end else if (rd_valid && rd_dirty) begin
            state_n     = WB;
            mem_req_n   = 1'b1;
            mem_we_n    = 1'b1;
            mem_addr_n  = {rd_tag, req_addr[6:5], 5'b0};
            mem_wline_n = rd_line;
          end else begin
            state_n    = FILL;
            mem_req_n  = 1'b1;
            mem_we_n   = 1'b0;
            mem_addr_n = {req_addr[31:5], 5'b0};
          end
        end
      end
      WB: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          state_n   = FILL;
        end
      end
      FILL: begin
        // Coming from WB, mem_req is low for one cycle before the fetch is issued.
        if (!mem_req) begin
          mem_req_n  = 1'b1;
          mem_we_n   = 1'b0;
          mem_addr_n = {lat_addr[31:5], 5'b0};
        end else if (mem_ack) begin
          mem_req_n    = 1'b0;
          state_n      = IDLE;
          resp_valid_n = 1'b1;
          line_we      = 1'b1;
          tag_we       = 1'b1;
          valid_we     = 1'b1;
          wr_valid     = 1'b1;
          dirty_we     = 1'b1;
          if (lat_write) begin
            wr_line  = merge_word(mem_rline, lat_addr[4:2], lat_wdata);
            wr_dirty = 1'b1;
          end else begin
            wr_line      = mem_rline;
            resp_rdata_n = get_word(mem_rline, lat_addr[4:2]);
          end
        end
      end
      FLUSH_SCAN: begin
        if (rd_valid && rd_dirty) begin
          state_n     = FLUSH_WB;
          mem_req_n   = 1'b1;
          mem_we_n    = 1'b1;
          mem_addr_n  = {rd_tag, ptr, 5'b0};
          mem_wline_n = rd_line;
        end else if (ptr == 2'd3) begin
          state_n      = IDLE;
          flush_done_n = 1'b1;
        end else begin
          ptr_n = ptr + 2'd1;
        end
      end
      FLUSH_WB: begin
        if (mem_ack) begin
          mem_req_n = 1'b0;
          dirty_we  = 1'b1;
          wr_dirty  = 1'b0;
          if (ptr == 2'd3) begin
            state_n      = IDLE;
            flush_done_n = 1'b1;
          end else begin
            state_n = FLUSH_SCAN;
            ptr_n   = ptr + 2'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 2'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wline  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      flush_done <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      mem_req    <= mem_req_n;
      mem_we     <= mem_we_n;
      mem_addr   <= mem_addr_n;
      mem_wline  <= mem_wline_n;
      resp_valid <= resp_valid_n;
      resp_rdata <= resp_rdata_n;
      flush_done <= flush_done_n;
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr[31:2];
        lat_wdata <= req_wdata;
      end
    end
  end
endmodule

// File: tb/tb_datacache.sv
// tb/tb_datacache.sv - self-checking bench for datacache against a word-level memory model
module tb_datacache;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_write, req_ready;
  logic [31:0]  req_addr, req_wdata;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         flush, flush_done;
  logic         mem_req, mem_we, mem_ack;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wline, mem_rline;

  datacache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .flush      (flush),
    .flush_done (flush_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wline  (mem_wline),
    .mem_ack    (mem_ack),
    .mem_rline  (mem_rline)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  typedef struct packed { logic we; logic [31:0] addr; } tx_t;
  tx_t log[$];

  // Backing memory and the CPU-visible (architectural) word values.
  logic [31:0] mem_words [logic [31:0]];
  logic [31:0] arch      [logic [31:0]];
  bit          mv [4];
  bit          md [4];
  logic [24:0] mt [4];

  int  mem_lat  = 0;
  bit  ack_hold = 0;
  int  ack_cyc  = 0;
  bit  busy = 0, prev_ack = 0;
  int  cnt = 0;
  logic [31:0] t_addr;
  logic        t_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a * 32'h0001_0003 + 32'h1357_2468;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_words.exists(a) ? mem_words[a] : init_word(a);
  endfunction

  function automatic logic [31:0] arch_word(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : mem_word(a);
  endfunction

  // Memory responder: ack after mem_lat waiting cycles, verify handshake rules.
  always @(negedge clk) begin
    if (prev_ack) begin
      chk("mem_req_drop", 32'(mem_req), 32'h0);
      prev_ack = 0;
    end
    mem_ack = 1'b0;
    if (!rst_n) begin
      busy = 0;
      cnt  = 0;
    end else if (mem_req) begin
      if (!busy) begin
        busy = 1; cnt = 0; t_addr = mem_addr; t_we = mem_we;
      end else begin
        chk("mem_addr_stable", mem_addr, t_addr);
      end
      if (!ack_hold && cnt >= mem_lat) begin
        mem_ack = 1'b1; busy = 0; prev_ack = 1; ack_cyc = cyc;
        log.push_back('{we: t_we, addr: t_addr});
        for (int k = 0; k < 8; k++) begin
          if (t_we) begin
            chk("wb_word", mem_wline[k*32 +: 32], arch_word(t_addr + 32'(4*k)));
            mem_words[t_addr + 32'(4*k)] = mem_wline[k*32 +: 32];
          end else begin
            mem_rline[k*32 +: 32] = mem_word(t_addr + 32'(4*k));
          end
        end
      end else begin
        cnt++;
      end
    end else begin
      busy = 0;
    end
  end

  task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd);
    int idx, n, acc_cyc, exp_n;
    logic [24:0] tg;
    bit hit, vic_wb, got;
    logic [31:0] exp_rd, wa;
    idx = int'(addr[6:5]);
    tg  = addr[31:7];
    wa  = {addr[31:2], 2'b00};
    hit = mv[idx] && (mt[idx] == tg);
    vic_wb = !hit && mv[idx] && md[idx];
    exp_rd = wr ? 32'h0 : arch_word(wa);
    log.delete();
    rd = '0;
    @(negedge clk);
    mem_lat = $urandom_range(0, 3);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_accept", 32'(req_ready), 32'h1);
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      if (resp_valid) begin got = 1; rd = resp_rdata; end
      else @(negedge clk);
    end
    chk("resp_seen", 32'(got), 32'h1);
    if (hit) begin
      chk("hit_latency", 32'(cyc - acc_cyc), 32'h1);
      chk("hit_no_mem", 32'(log.size()), 32'h0);
    end else begin
      exp_n = vic_wb ? 2 : 1;
      chk("miss_ntx", 32'(log.size()), 32'(exp_n));
      if (log.size() == exp_n) begin
        if (vic_wb) begin
          chk("wb_we", 32'(log[0].we), 32'h1);
          chk("wb_addr", log[0].addr, {mt[idx], addr[6:5], 5'b0});
        end
        chk("fill_we", 32'(log[exp_n-1].we), 32'h0);
        chk("fill_addr", log[exp_n-1].addr, {addr[31:5], 5'b0});
      end
      chk("miss_latency", 32'(cyc - ack_cyc), 32'h1);
    end
    chk("rdata", rd, exp_rd);
    if (wr) arch[wa] = wd;
    md[idx] = hit ? (md[idx] | wr) : wr;
    mv[idx] = 1;
    mt[idx] = tg;
  endtask

  task automatic do_flush(input bit with_req, input logic [31:0] ra);
    logic [31:0] exp_a[$];
    int n, rdy_hi;
    bit clean, seen;
    for (int i = 0; i < 4; i++)
      if (mv[i] && md[i]) exp_a.push_back({mt[i], 2'(i), 5'b0});
    clean = (exp_a.size() == 0);
    log.delete();
    @(negedge clk);
    mem_lat = $urandom_range(0, 3);
    flush = 1'b1;
    if (with_req) begin req_valid = 1'b1; req_write = 1'b0; req_addr = ra; end
    n = 0; rdy_hi = 0; seen = 0;
    while (n < 500 && !seen) begin
      @(negedge clk); n++;
      if (req_ready) rdy_hi++;
      if (flush_done) seen = 1;
    end
    chk("flush_done_seen", 32'(seen), 32'h1);
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush_ready_low", 32'(rdy_hi), 32'h0);
    chk("flush_ntx", 32'(log.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < log.size(); i++) begin
      chk("flush_we", 32'(log[i].we), 32'h1);
      chk("flush_addr", log[i].addr, exp_a[i]);
    end
    if (clean) chk("clean_flush_cycles", 32'(n), 32'h5);
    @(negedge clk);
    chk("flush_done_pulse", 32'(flush_done), 32'h0);
    for (int i = 0; i < 4; i++) md[i] = 0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_n;
    logic [31:0] exp_a0;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    int n;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rline = '0;
    for (int i = 0; i < 4; i++) begin mv[i] = 0; md[i] = 0; mt[i] = '0; end
    mem_words[32'h84] = 32'hDEAD_BEEF;

    vecs.push_back('{0, 32'h84,  32'h0,         32'hDEAD_BEEF,      1, 32'h80});
    vecs.push_back('{0, 32'h84,  32'h0,         32'hDEAD_BEEF,      0, 32'h0});
    vecs.push_back('{1, 32'h88,  32'h1234_5678, 32'h0,              0, 32'h0});
    vecs.push_back('{0, 32'h88,  32'h0,         32'h1234_5678,      0, 32'h0});
    vecs.push_back('{0, 32'h108, 32'h0,         init_word(32'h108), 2, 32'h80});
    vecs.push_back('{1, 32'h200, 32'hAAAA_5555, 32'h0,              1, 32'h200});
    vecs.push_back('{0, 32'h204, 32'h0,         init_word(32'h204), 0, 32'h0});

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_flush_done", 32'(flush_done), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wline", mem_wline[31:0], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'h1);

    foreach (vecs[i]) begin
      do_op(vecs[i].wr, vecs[i].addr, vecs[i].wd, rd);
      chk("vec_rdata", rd, vecs[i].exp_rd);
      chk("vec_ntx", 32'(log.size()), 32'(vecs[i].exp_n));
      if (vecs[i].exp_n > 0 && log.size() > 0) chk("vec_addr0", log[0].addr, vecs[i].exp_a0);
    end

    do_flush(0, 32'h0);
    do_flush(1, 32'h204);
    do_op(0, 32'h204, 32'h0, rd);

    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_flush($urandom_range(0, 1) == 1, 32'h40);
      end else begin
        a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 3)) << 5)
          | (32'($urandom_range(0, 7)) << 2);
        do_op($urandom_range(0, 1) == 1, a, $urandom, rd);
      end
    end

    do_flush(0, 32'h0);
    ack_hold = 1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_8064;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!(mem_req && !mem_we) && n < 50) begin @(negedge clk); n++; end
    chk("fill_pending", 32'(mem_req), 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abandon_mem_req", 32'(mem_req), 32'h0);
    chk("abandon_resp", 32'(resp_valid), 32'h0);
    chk("reset_ready_low", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    ack_hold = 0;
    for (int i = 0; i < 4; i++) begin mv[i] = 0; md[i] = 0; end
    arch = mem_words;
    @(negedge clk);
    chk("no_resp_after_reset", 32'(resp_valid), 32'h0);
    do_op(0, 32'h0000_8064, 32'h0, rd);
    do_op(0, 32'h84, 32'h0, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
